// File: rtl/contatore_gray_n.sv
`default_nettype none
// ============================================================================
// Module   : contatore_gray_n
// Brief    : Parametrised up/down Gray counter with load, saturate option,
//            terminal count and wrap pulse; exposes Gray and binary views.
// Revision : 1.0 - initial release
// ============================================================================

module contatore_gray_n #(
   parameter int WIDTH    = 3,
   parameter int SATURATE = 0,
   parameter int INIT     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] bin,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] c_max  = '1;
   localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_init = WIDTH'(INIT);

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;

   logic [WIDTH-1:0] w_count;
   logic [WIDTH-1:0] w_bin_next;
   logic             w_tc;
   logic             w_wrap_next;

   assign w_tc = up ? (r_bin == c_max) : (r_bin == '0);

   generate
      if (SATURATE != 0) begin : g_sat
         // Hold at whichever end of the range the current direction points to.
         always_comb begin
            w_count = r_bin;
            if (!w_tc) begin
               w_count = up ? (r_bin + c_one) : (r_bin - c_one);
            end
         end
         assign w_wrap_next = 1'b0;
      end else begin : g_mod
         assign w_count     = up ? (r_bin + c_one) : (r_bin - c_one);
         assign w_wrap_next = en & ~load & w_tc;
      end
   endgenerate

   always_comb begin
      w_bin_next = r_bin;
      if (load) begin
         w_bin_next = d_in;
      end else if (en) begin
         w_bin_next = w_count;
      end
   end

   // Gray is derived from the next binary value so both views update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bin  <= c_init;
         r_gray <= c_init ^ (c_init >> 1);
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_bin_next ^ (w_bin_next >> 1);
         r_wrap <= w_wrap_next;
      end
   end

   assign y    = r_gray;
   assign bin  = r_bin;
   assign tc   = w_tc;
   assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: doc/contatore_gray_n.md
# contatore_gray_n

Parametrised Gray-code counter, successor to the fixed 3-bit Gray counter. It adds configurable width, count enable, up/down direction, synchronous parallel load, and a choice between modulo and saturating behaviour. It also provides terminal-count and wrap indications. The block sits in the datapath wherever a glitch-free, single-bit-change count is needed, for example as a FIFO pointer or a clock-domain-crossing position code, and exposes both the Gray and the binary views of the count.

## Interface
- WIDTH, default 3: counter width in bits, legal range 2..16.
- SATURATE, default 0: 0 = modulo (wrap-around), 1 = hold at the end of range.
- INIT, default 0: binary value loaded on reset, range 0..2^WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. 0 resets the block immediately; release is sampled by clk.
- en  in  1  count enable. When 1, the counter advances one step per clock.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load. Has priority over en.
- d_in  in  WIDTH  binary value to load.
- y  out  WIDTH  registered Gray-coded count.
- bin  out  WIDTH  registered binary count (internal state).
- tc  out  1  combinational terminal count.
- wrap  out  1  registered one-cycle pulse.

## Operation
- State is binary register b. Gray register y is updated on the same edge from the next value: y_next = b_next ^ (b_next >> 1). y is never decoded combinationally at the output.
- Next-value priority, evaluated each rising edge:
  - load=1: b_next = d_in, regardless of en and up.
  - load=0, en=1, up=1: b_next = b+1 mod 2^WIDTH. If SATURATE=1 and b = 2^WIDTH-1, b holds.
  - load=0, en=1, up=0: b_next = b-1 mod 2^WIDTH. If SATURATE=1 and b = 0, b holds.
  - load=0, en=0: hold.
- All arithmetic is unsigned at WIDTH bits. Carry and borrow are discarded.
- tc = (up & b == 2^WIDTH-1) | (~up & b == 0). It is independent of en and load.
- wrap is set to 1 for exactly one cycle after an edge where load=0, en=1, tc=1 and SATURATE=0. Otherwise it is 0. In saturate mode wrap is always 0.
- Consecutive y values produced by counting, including across the wrap, differ in exactly one bit. A load may change any number of bits.
- Reset (reset=0), asynchronous and at any time including mid-count or mid-load:
  - b = INIT and y = gray(INIT).
  - wrap = 0.
  - tc follows b and up.
- First possible count edge is the first rising clk with reset=1.

## Timing
- Latency from inputs (en, up, load, d_in) to y and bin is 1 clock. The new value is visible after the sampling edge.
- tc is a zero-cycle combinational path from b and up. A change on up changes tc in the same cycle.
- wrap is asserted in the cycle following the wrapping edge, coincident with y = gray(0) (up) or gray(2^WIDTH-1) (down).
- If load and the terminal condition coincide, load wins and wrap stays 0.
- Changing direction has no penalty: the next enabled edge moves in the new direction.
- en low for any number of cycles holds y, bin and tc. wrap drops to 0 after one cycle.

## Test plan
- Reset, WIDTH=3, INIT=0: drive reset=0 mid-cycle. Required: y=000, bin=000, wrap=0 immediately, without waiting for a clock edge. Release reset, then hold en=0 for 3 clocks. Required: y stays 000.
- Count up, en=1, up=1, 9 clocks: y sequence 000,001,011,010,110,111,101,100,000. tc=1 while y=100. wrap=1 only in the cycle with the final 000. Every step changes exactly one bit.
- Count down from 000, 3 clocks: y=100, 101, 111. wrap=1 in the cycle y=100. tc=1 while y=000 and up=0 before the first edge.
- Load priority: while counting at bin=5, apply load=1, en=1, d_in=3. Required: bin=3, y=010 next cycle, wrap=0. Then count resumes to bin=4, y=110.
- Saturate, SATURATE=1, WIDTH=4: up from bin=14 for 3 clocks gives bin=15,15,15 and y=1000 held, with wrap never 1. Down from bin=1 gives 0,0 and holds.
- Reset mid-operation, INIT=5: assert reset=0 while counting at bin=2. Required: bin=101 and y=111 asynchronously. After release, the next up edge gives bin=6, y=101.
